// File: rtl/regfile_sb.sv
// regfile_sb: integer register file for the pipelined RV core, with
// busy-bit scoreboard.
//
// Two write ports feed the file: port 0 is ALU writeback and port 1 is load
// writeback. It has NRD combinational read ports. When BYPASS is set, a write
// in the current cycle is forwarded to any read port whose address it hits.
// Decode uses one busy bit per register to stall on RAW hazards.
//
// Ports
//   clk        rising-edge clock
//   resetn     synchronous active-low reset (clears registers and busy bits)
//   rs_addr    NRD packed read addresses, port k at [k*AW +: AW]
//   rs_data    NRD packed read data, port k at [k*XLEN +: XLEN]
//   rs_busy    per-port pending-write flag
//   iss_valid  issue of an instruction that will write iss_rd
//   iss_rd     destination of the issued instruction
//   we0/wa0/wd0  ALU writeback
//   we1/wa1/wd1  load writeback (wins a same-address collision)
//   flush      clears all busy bits and drops a same-cycle issue
//   busy_any   OR of the registered busy bits
module regfile_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NRD*AW-1:0]     rs_addr,
    output logic [NRD*XLEN-1:0]   rs_data,
    output logic [NRD-1:0]        rs_busy,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [XLEN-1:0]       wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [XLEN-1:0]       wd1,
    input  logic                  flush,
    output logic                  busy_any
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_val;
    logic            rd_bsy;

    // Port 1 is applied last so that it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (we0 && wa0 != '0) regs_d[wa0] = wd0;
        if (we1 && wa1 != '0) regs_d[wa1] = wd1;
        regs_d[0] = '0;
    end

    // Lowest priority is assigned first: write clears, issue sets, flush clears.
    // The issue overrides the write because the write belongs to an older
    // instruction.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r))) busy_d[r] = 1'b0;
            if (iss_valid && iss_rd == AW'(r))                    busy_d[r] = 1'b1;
            if (flush)                                            busy_d[r] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            busy_q <= busy_d;
        end
    end

    // The read ports ignore the current-cycle issue. Only writes are forwarded.
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        rd_addr = '0;
        rd_val  = '0;
        rd_bsy  = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            rd_addr = rs_addr[k*AW +: AW];
            rd_val  = regs_q[rd_addr];
            rd_bsy  = busy_q[rd_addr];
            if (BYPASS != 0) begin
                if (we0 && wa0 == rd_addr) begin
                    rd_val = wd0;
                    rd_bsy = 1'b0;
                end
                if (we1 && wa1 == rd_addr) begin
                    rd_val = wd1;
                    rd_bsy = 1'b0;
                end
            end
            if (rd_addr == '0) begin
                rd_val = '0;
                rd_bsy = 1'b0;
            end
            rs_data[k*XLEN +: XLEN] = rd_val;
            rs_busy[k]              = rd_bsy;
        end
    end

    assign busy_any = |busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A uses the defaults: 64-bit, 32 registers, 2 read ports, bypass.
    logic         a_resetn, a_iss_valid, a_we0, a_we1, a_flush, a_busy_any;
    logic [9:0]   a_rs_addr;
    logic [127:0] a_rs_data;
    logic [1:0]   a_rs_busy;
    logic [4:0]   a_iss_rd, a_wa0, a_wa1;
    logic [63:0]  a_wd0, a_wd1;

    // Instance B: 32-bit, 16 registers, 3 read ports, no bypass.
    logic         b_resetn, b_iss_valid, b_we0, b_we1, b_flush, b_busy_any;
    logic [11:0]  b_rs_addr;
    logic [95:0]  b_rs_data;
    logic [2:0]   b_rs_busy;
    logic [3:0]   b_iss_rd, b_wa0, b_wa1;
    logic [31:0]  b_wd0, b_wd1;

    regfile_sb u_dut_a (
        .clk(clk), .resetn(a_resetn), .rs_addr(a_rs_addr), .rs_data(a_rs_data),
        .rs_busy(a_rs_busy), .iss_valid(a_iss_valid), .iss_rd(a_iss_rd),
        .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0), .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
        .flush(a_flush), .busy_any(a_busy_any)
    );

    regfile_sb #(.XLEN(32), .NREG(16), .NRD(3), .BYPASS(0)) u_dut_b (
        .clk(clk), .resetn(b_resetn), .rs_addr(b_rs_addr), .rs_data(b_rs_data),
        .rs_busy(b_rs_busy), .iss_valid(b_iss_valid), .iss_rd(b_iss_rd),
        .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
        .flush(b_flush), .busy_any(b_busy_any)
    );

    // Field codes: 0..2 = rs_data port k, 3 = rs_busy vector, 4 = busy_any.
    typedef struct {
        string       tag;
        int          dut;
        int          fld;
        logic [63:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int dut, input int fld, input logic [63:0] exp);
        sb_t e;
        e.tag = tag;
        e.dut = dut;
        e.fld = fld;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    function automatic logic [63:0] peek(input int dut, input int fld);
        logic [63:0] v;
        v = '0;
        if (dut == 0) begin
            case (fld)
                0: v = a_rs_data[63:0];
                1: v = a_rs_data[127:64];
                3: v = {62'd0, a_rs_busy};
                4: v = {63'd0, a_busy_any};
                default: v = 'x;
            endcase
        end else begin
            case (fld)
                0: v = {32'd0, b_rs_data[31:0]};
                1: v = {32'd0, b_rs_data[63:32]};
                2: v = {32'd0, b_rs_data[95:64]};
                3: v = {61'd0, b_rs_busy};
                4: v = {63'd0, b_busy_any};
                default: v = 'x;
            endcase
        end
        return v;
    endfunction

    // Let the combinational outputs settle, then drain the scoreboard.
    task automatic settle_chk();
        sb_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, peek(e.dut, e.fld), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic a_idle();
        a_iss_valid = 0; a_iss_rd = '0; a_we0 = 0; a_wa0 = '0; a_wd0 = '0;
        a_we1 = 0; a_wa1 = '0; a_wd1 = '0; a_flush = 0;
    endtask

    task automatic b_idle();
        b_iss_valid = 0; b_iss_rd = '0; b_we0 = 0; b_wa0 = '0; b_wd0 = '0;
        b_we1 = 0; b_wa1 = '0; b_wd1 = '0; b_flush = 0;
    endtask

    task automatic a_iss(input logic [4:0] rd);
        a_iss_valid = 1; a_iss_rd = rd;
    endtask

    task automatic b_iss(input logic [3:0] rd);
        b_iss_valid = 1; b_iss_rd = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_idle(); b_idle();
        a_resetn = 0; b_resetn = 0;
        a_rs_addr = '0; b_rs_addr = '0;
        tick(); tick();
        sb_push("a_rst_bany", 0, 4, 64'd0);
        sb_push("a_rst_busy", 0, 3, 64'd0);
        settle_chk();

        // Write reg 5, then reset while a write and an issue are also active.
        a_resetn = 1;
        a_we0 = 1; a_wa0 = 5; a_wd0 = 64'hDEAD;
        tick();
        a_idle(); a_rs_addr = {5'd0, 5'd5};
        sb_push("a_wr5", 0, 0, 64'hDEAD);
        settle_chk();
        a_resetn = 0;
        a_we0 = 1; a_wa0 = 5; a_wd0 = 64'h1111; a_iss(5'd6);
        tick();
        a_resetn = 1; a_idle(); a_rs_addr = {5'd0, 5'd5};
        sb_push("a_rst_d0", 0, 0, 64'd0);
        sb_push("a_rst_d1", 0, 1, 64'd0);
        sb_push("a_rst_busy2", 0, 3, 64'd0);
        sb_push("a_rst_bany2", 0, 4, 64'd0);
        settle_chk();

        // Scoreboard lifecycle on reg 7.
        a_iss(5'd7); a_rs_addr = {5'd0, 5'd7};
        sb_push("a_iss_same_busy", 0, 3, 64'd0);
        sb_push("a_iss_same_bany", 0, 4, 64'd0);
        settle_chk();
        tick();
        a_idle();
        sb_push("a_iss7_busy", 0, 3, 64'd1);
        sb_push("a_iss7_bany", 0, 4, 64'd1);
        settle_chk();
        a_we0 = 1; a_wa0 = 7; a_wd0 = 64'h1234;
        sb_push("a_wb7_byp_d", 0, 0, 64'h1234);
        sb_push("a_wb7_byp_busy", 0, 3, 64'd0);
        sb_push("a_wb7_byp_bany", 0, 4, 64'd1);
        settle_chk();
        tick();
        a_idle();
        sb_push("a_wb7_d", 0, 0, 64'h1234);
        sb_push("a_wb7_busy", 0, 3, 64'd0);
        sb_push("a_wb7_bany", 0, 4, 64'd0);
        settle_chk();

        // Both write ports hit reg 3; port 1 wins.
        a_we0 = 1; a_wa0 = 3; a_wd0 = 64'hAAAA;
        a_we1 = 1; a_wa1 = 3; a_wd1 = 64'h5555;
        a_rs_addr = {5'd3, 5'd0};
        sb_push("a_coll_byp", 0, 1, 64'h5555);
        sb_push("a_coll_x0", 0, 0, 64'd0);
        settle_chk();
        tick();
        a_idle();
        sb_push("a_coll_reg", 0, 1, 64'h5555);
        sb_push("a_coll_busy", 0, 3, 64'd0);
        settle_chk();

        // Issue to reg 9 races a load writeback to reg 9.
        a_iss(5'd9);
        tick();
        a_idle(); a_rs_addr = {5'd3, 5'd9};
        sb_push("a_iss9_busy", 0, 3, 64'd1);
        sb_push("a_iss9_bany", 0, 4, 64'd1);
        settle_chk();
        a_we1 = 1; a_wa1 = 9; a_wd1 = 64'h77; a_iss(5'd9);
        sb_push("a_race_byp_d", 0, 0, 64'h77);
        sb_push("a_race_byp_busy", 0, 3, 64'd0);
        settle_chk();
        tick();
        a_idle();
        sb_push("a_race_d", 0, 0, 64'h77);
        sb_push("a_race_busy", 0, 3, 64'd1);
        sb_push("a_race_bany", 0, 4, 64'd1);
        settle_chk();

        // Register 0 ignores both issue and write.
        a_iss(5'd0); a_we0 = 1; a_wa0 = 0; a_wd0 = 64'hFFFF;
        a_rs_addr = {5'd9, 5'd0};
        sb_push("a_x0_byp_d", 0, 0, 64'd0);
        sb_push("a_x0_byp_busy", 0, 3, 64'd2);
        settle_chk();
        tick();
        a_idle();
        sb_push("a_x0_d", 0, 0, 64'd0);
        sb_push("a_x0_busy", 0, 3, 64'd2);
        sb_push("a_x0_bany", 0, 4, 64'd1);
        settle_chk();

        // Flush with a simultaneous issue.
        a_iss(5'd1); tick();
        a_iss(5'd2); tick();
        a_iss(5'd31); tick();
        a_idle(); a_rs_addr = {5'd31, 5'd1};
        sb_push("a_pre_flush_busy", 0, 3, 64'd3);
        settle_chk();
        a_flush = 1; a_iss(5'd4); a_rs_addr = {5'd2, 5'd4};
        sb_push("a_flush_same_busy", 0, 3, 64'd2);
        settle_chk();
        tick();
        a_idle(); a_rs_addr = {5'd31, 5'd4};
        sb_push("a_flush_busy", 0, 3, 64'd0);
        sb_push("a_flush_bany", 0, 4, 64'd0);
        settle_chk();

        // Instance B: no bypass, so writes appear one cycle later.
        b_resetn = 1; b_idle(); b_rs_addr = {4'd6, 4'd0, 4'd6};
        sb_push("b_rst_busy", 1, 3, 64'd0);
        sb_push("b_rst_bany", 1, 4, 64'd0);
        settle_chk();
        b_we0 = 1; b_wa0 = 6; b_wd0 = 32'hCAFEF00D;
        sb_push("b_nobyp_d0", 1, 0, 64'd0);
        sb_push("b_nobyp_d2", 1, 2, 64'd0);
        settle_chk();
        tick();
        b_idle();
        sb_push("b_wr_d0", 1, 0, 64'hCAFEF00D);
        sb_push("b_wr_d2", 1, 2, 64'hCAFEF00D);
        settle_chk();
        b_iss(4'd6); tick();
        b_idle();
        sb_push("b_iss6_busy", 1, 3, 64'd5);
        sb_push("b_iss6_bany", 1, 4, 64'd1);
        settle_chk();
        b_we0 = 1; b_wa0 = 6; b_wd0 = 32'hAAAAAAAA;
        b_we1 = 1; b_wa1 = 6; b_wd1 = 32'h12345678;
        sb_push("b_coll_nobyp_d", 1, 0, 64'hCAFEF00D);
        sb_push("b_coll_nobyp_busy", 1, 3, 64'd5);
        settle_chk();
        tick();
        b_idle();
        sb_push("b_coll_d", 1, 0, 64'h12345678);
        sb_push("b_coll_busy", 1, 3, 64'd0);
        sb_push("b_coll_bany", 1, 4, 64'd0);
        settle_chk();
        b_iss(4'd1); tick();
        b_iss(4'd2); tick();
        b_iss(4'd15); tick();
        b_idle(); b_rs_addr = {4'd15, 4'd2, 4'd1};
        sb_push("b_pre_flush_busy", 1, 3, 64'd7);
        settle_chk();
        b_flush = 1; b_iss(4'd4);
        tick();
        b_idle(); b_rs_addr = {4'd15, 4'd2, 4'd4};
        sb_push("b_flush_busy", 1, 3, 64'd0);
        sb_push("b_flush_bany", 1, 4, 64'd0);
        settle_chk();
        b_rs_addr = {4'd0, 4'd6, 4'd0};
        sb_push("b_x0_d", 1, 0, 64'd0);
        sb_push("b_r6_d", 1, 1, 64'h12345678);
        settle_chk();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the pipelined RV core. It generalises the single-write, two-read file to configurable width, depth and read-port count. It adds two write ports (ALU writeback and load writeback), optional write-to-read bypass, and a per-register busy scoreboard. Issue/decode uses the scoreboard to stall on RAW hazards. It sits between decode (reads, issue) and the two writeback stages.

Parameters:
XLEN, 64, data width in bits (32 or 64)
NREG, 32, number of architectural registers; power of two, 2..32; register 0 hardwired to zero
NRD, 2, number of read ports, 1..4
BYPASS, 1, 1 = a same-cycle write is forwarded to the read data and clears the read busy flag; 0 = reads see registered state only
AW (localparam), $clog2(NREG), register address width

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  synchronous active-low reset
rs_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
rs_data  out  NRD*XLEN  read data, combinational, port k at [k*XLEN +: XLEN]
rs_busy  out  NRD  1 = register addressed by port k has a pending write
iss_valid  in  1  instruction issued that will write iss_rd
iss_rd  in  AW  destination of issued instruction
we0  in  1  write enable, port 0 (ALU writeback)
wa0  in  AW  write address, port 0
wd0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1 (load writeback)
wa1  in  AW  write address, port 1
wd1  in  XLEN  write data, port 1
flush  in  1  pipeline flush: clear all busy bits
busy_any  out  1  OR of all busy bits (registered state)

Behaviour:
- Reset is synchronous: on a rising clk edge with resetn=0, all registers become 0 and all busy bits become 0. This overrides writes, issue and flush in that cycle. After that edge, rs_data=0, rs_busy=0 and busy_any=0.
- Register 0:
  - Never written.
  - Its busy bit is never set.
  - Reads of address 0 return 0 with busy=0 regardless of BYPASS.
- Writes: on the clock edge, if weN=1 and waN!=0, then reg[waN] <= wdN.
  - If both ports target the same nonzero address in one cycle, port 1 (load) wins the data.
  - Both writes are accepted; no error is raised.
- Busy bits, per register r != 0, next-state priority (highest first):
  1. reset, then 0
  2. flush=1, then 0; a same-cycle issue is also discarded
  3. iss_valid=1 and iss_rd=r, then 1; issue wins over a same-cycle write to r, because the write belongs to an older instruction
  4. (we0 and wa0=r) or (we1 and wa1=r), then 0
  5. otherwise hold
  - A write to a non-busy register is legal: the data is written and the busy bit stays 0.
- Reads are purely combinational, with zero-cycle latency.
  - BYPASS=0:
    - rs_data[k] = reg[rs_addr k]
    - rs_busy[k] = busy[rs_addr k]
  - BYPASS=1, if a write in the current cycle hits the read address (nonzero):
    - rs_data[k] = that write data, with port 1 taking priority over port 0
    - rs_busy[k] = 0
  - The current-cycle issue never affects rs_data or rs_busy in the same cycle.
- busy_any is taken from the registered busy vector only; there is no bypass on it.
- Mid-operation reset or flush: no multi-cycle state exists, so everything is consistent after one edge.
- The array is implemented as flops, not inferred RAM, to allow NRD async reads and synchronous reset.

Test Plan:
1. Reset then read:
   - Stimulus: resetn=0 for 1 edge after writing reg 5 = 0xDEAD; then read rs_addr={5,0}.
   - Required: rs_data={0,0}, rs_busy=0, busy_any=0.
2. Scoreboard lifecycle:
   - Stimulus: iss_valid with iss_rd=7, then read 7.
   - Required: rs_busy=1, busy_any=1.
   - Stimulus: we0, wa0=7, wd0=0x1234, with BYPASS=1.
   - Required: the same cycle reads 0x1234 with busy 0; the next cycle reads 0x1234 with busy 0 and busy_any=0.
3. Dual-write collision:
   - Stimulus: we0/we1 both to reg 3 with wd0=0xAAAA and wd1=0x5555.
   - Required: same-cycle bypass read = 0x5555; reg 3 = 0x5555 after the edge.
4. Issue vs writeback race:
   - Stimulus: reg 9 busy; in one cycle, we1 to 9 with 0x77 and iss_valid with iss_rd=9.
   - Required: next cycle reg 9 reads 0x77 and rs_busy=1.
5. x0 protection:
   - Stimulus: iss_valid with iss_rd=0, and we0 with wa0=0, wd0=0xFFFF.
   - Required: read of 0 returns 0, busy=0, busy_any unchanged.
6. Flush plus parameters:
   - Stimulus: set busy on regs 1, 2, 31; assert flush together with iss_rd=4.
   - Required: all busy=0 next cycle.
   - Repeat with XLEN=32, NREG=16, NRD=3, BYPASS=0.
   - Required: a same-cycle write to r is not visible on the read until the next cycle.
